ifu_prefetch: RTL and testbench

Parametrised instruction-fetch unit with a prefetch queue. It generates sequential fetch addresses, issues them to the instruction ROM over a valid/ready request channel, and buffers in-order ROM responses in a FIFO. It presents {pc, instruction} pairs to the decode-stage DFF over a valid/ready handshake. Redirects (jump/branch) flush the queue and discard stale in-flight responses; it sits between pc control and decode.

---
 rtl/ifu_prefetch_pkg.sv | 13 +
 rtl/ifu_pf_fifo.sv | 67 ++++++
 rtl/ifu_prefetch.sv | 120 ++++++++++++
 tb/tb_ifu_prefetch.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ifu_prefetch_pkg.sv
// Shared constants for the instruction-fetch prefetch unit: default widths,
// pc step/reset address, enable levels and the reset active level.
package ifu_prefetch_pkg;

    localparam int          IFU_ADDR_W     = 32;
    localparam int          IFU_DATA_W     = 32;
    localparam int          IFU_PC_STEP    = 4;
    localparam logic [31:0] IFU_RESET_PC   = 32'h0;
    localparam logic        IFU_EN         = 1'b1;
    localparam logic        IFU_DIS        = 1'b0;
    localparam logic        IFU_RST_ACTIVE = 1'b1;

endpackage

// File: rtl/ifu_pf_fifo.sv
// Show-ahead synchronous FIFO holding {pc, instruction} entries for the
// prefetch unit. Flush empties it in one cycle; the head is always readable.
module ifu_pf_fifo
    import ifu_prefetch_pkg::*;
#(
    parameter int  WIDTH = IFU_ADDR_W + IFU_DATA_W,
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0] wr_en;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !flush;
    assign pop_ok  = pop && !flush && (count_reg != '0);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push_ok && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    // Storage is cleared on reset so the head reads as zero before any push.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst == IFU_RST_ACTIVE) begin
                mem_reg[i] <= '0;
            end else if (wr_en[i]) begin
                mem_reg[i] <= push_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst == IFU_RST_ACTIVE || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign empty     = (count_reg == '0);
    assign count     = count_reg;

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction-fetch unit with prefetch queue: issues sequential fetches under
// a credit limit, drops stale responses after redirects. Option: IFU_PF_BYPASS_EN.
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter int                ADDR_W   = IFU_ADDR_W,
    parameter int                DATA_W   = IFU_DATA_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC),
    parameter int                PC_STEP  = IFU_PC_STEP,
    localparam int               CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              hold_i,
    output logic              req_valid_o,
    output logic [ADDR_W-1:0] req_addr_o,
    input  logic              req_ready_i,
    input  logic              rsp_valid_i,
    input  logic [DATA_W-1:0] rsp_data_i,
    output logic              inst_valid_o,
    output logic [DATA_W-1:0] inst_data_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    input  logic              inst_ready_i,
    output logic [CNT_W-1:0]  fifo_count_o
);

`ifdef IFU_PF_BYPASS_EN
    localparam logic BYPASS_EN = IFU_EN;
`else
    localparam logic BYPASS_EN = IFU_DIS;
`endif
    localparam logic [CNT_W:0]    DEPTH_W = (CNT_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP_W  = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0]        fetch_pc_reg, fetch_pc_next;
    logic [ADDR_W-1:0]        rsp_pc_reg, rsp_pc_next;
    logic [CNT_W-1:0]         outstanding_reg, outstanding_next;
    logic [CNT_W-1:0]         drop_cnt_reg, drop_cnt_next;
    logic [CNT_W-1:0]         fifo_count;
    logic [CNT_W:0]           credit_used;
    logic [ADDR_W+DATA_W-1:0] fifo_head;
    logic                     in_reset;
    logic                     req_fire;
    logic                     rsp_keep;
    logic                     bypass_hit;
    logic                     fifo_empty;
    logic                     fifo_push;
    logic                     fifo_pop;

    assign in_reset = (rst == IFU_RST_ACTIVE);

    // Live in-flight requests plus queued entries; each live request owns a slot.
    assign credit_used = {1'b0, outstanding_reg} - {1'b0, drop_cnt_reg} + {1'b0, fifo_count};

    assign req_valid_o = !in_reset && !hold_i && !redirect_valid_i
                      && (credit_used < DEPTH_W)
                      && ({1'b0, outstanding_reg} < DEPTH_W);
    assign req_addr_o  = fetch_pc_reg;
    assign req_fire    = req_valid_o && req_ready_i;

    // A response arriving alongside a redirect is stale as well.
    assign rsp_keep   = rsp_valid_i && !redirect_valid_i && (drop_cnt_reg == '0);
    assign bypass_hit = BYPASS_EN && fifo_empty && rsp_keep;

    assign inst_valid_o = !in_reset && !redirect_valid_i && (!fifo_empty || bypass_hit);
    assign inst_pc_o    = bypass_hit ? rsp_pc_reg : fifo_head[ADDR_W+DATA_W-1 -: ADDR_W];
    assign inst_data_o  = bypass_hit ? rsp_data_i : fifo_head[DATA_W-1:0];
    assign fifo_pop     = inst_valid_o && inst_ready_i && !fifo_empty;
    assign fifo_push    = rsp_keep && !(bypass_hit && inst_ready_i);
    assign fifo_count_o = fifo_count;

    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        rsp_pc_next      = rsp_pc_reg;
        outstanding_next = outstanding_reg + CNT_W'(req_fire) - CNT_W'(rsp_valid_i);
        drop_cnt_next    = drop_cnt_reg;
        if (redirect_valid_i) begin
            fetch_pc_next = redirect_pc_i;
            rsp_pc_next   = redirect_pc_i;
            drop_cnt_next = outstanding_next;
        end else begin
            if (req_fire) fetch_pc_next = fetch_pc_reg + STEP_W;
            if (rsp_keep) rsp_pc_next = rsp_pc_reg + STEP_W;
            if (rsp_valid_i && drop_cnt_reg != '0) drop_cnt_next = drop_cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_reset) begin
            fetch_pc_reg    <= RESET_PC;
            rsp_pc_reg      <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            rsp_pc_reg      <= rsp_pc_next;
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= drop_cnt_next;
        end
    end

    ifu_pf_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({rsp_pc_reg, rsp_data_i}),
        .pop       (fifo_pop),
        .flush     (redirect_valid_i),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_ifu_prefetch.sv
// Randomized bench for ifu_prefetch: a transaction-level ROM and an epoch-tagged
// expected instruction queue predict every output cycle by cycle.
module tb_ifu_prefetch;

    localparam int DEPTH = 4;
`ifdef IFU_PF_BYPASS_EN
    localparam bit TB_BYP = 1'b1;
`else
    localparam bit TB_BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        hold_i;
    logic        req_valid_o;
    logic [31:0] req_addr_o;
    logic        req_ready_i;
    logic        rsp_valid_i;
    logic [31:0] rsp_data_i;
    logic        inst_valid_o;
    logic [31:0] inst_data_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;
    logic [2:0]  fifo_count_o;

    ifu_prefetch #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .hold_i           (hold_i),
        .req_valid_o      (req_valid_o),
        .req_addr_o       (req_addr_o),
        .req_ready_i      (req_ready_i),
        .rsp_valid_i      (rsp_valid_i),
        .rsp_data_i       (rsp_data_i),
        .inst_valid_o     (inst_valid_o),
        .inst_data_o      (inst_data_o),
        .inst_pc_o        (inst_pc_o),
        .inst_ready_i     (inst_ready_i),
        .fifo_count_o     (fifo_count_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

    req_t pend[$];          // requests accepted by the ROM, oldest first
    ent_t expq[$];          // instructions the unit should be holding
    int   epoch      = 0;
    int   cyc        = 0;
    int   last_due   = 0;
    logic [31:0] exp_req_pc = 32'h0;

    int   n_vec = 0;
    int   n_err = 0;

    bit          hold_s, redir_s, rdy_s, irdy_s;
    logic [31:0] redir_pc_s;
    int          lat_s;

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h20) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst = 1'b1; hold_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = '0;
        req_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_data_i = '0; inst_ready_i = 1'b0;
        repeat (n) @(posedge clk);
        #4;
        chk("rst_req_valid", req_valid_o, 0);
        chk("rst_inst_valid", inst_valid_o, 0);
        chk("rst_inst_data", inst_data_o, 0);
        chk("rst_inst_pc", inst_pc_o, 0);
        chk("rst_fifo_count", fifo_count_o, 0);
        pend.delete(); expq.delete();
        epoch++; exp_req_pc = 32'h0; last_due = cyc;
        rst = 1'b0;
    endtask

    task automatic step();
        bit   rsp_v, rsp_stale, byp, exp_rv, exp_iv;
        req_t r;
        ent_t e;
        int   live;
        @(posedge clk); #1;
        cyc++;
        rsp_v = (pend.size() > 0) && (pend[0].due <= cyc);
        if (rsp_v) r = pend[0];
        hold_i = hold_s; redirect_valid_i = redir_s; redirect_pc_i = redir_pc_s;
        req_ready_i = rdy_s; inst_ready_i = irdy_s; rsp_valid_i = rsp_v;
        rsp_data_i = rsp_v ? rom(r.addr) : $urandom;
        #4;
        live = 0;
        foreach (pend[i]) if (pend[i].epoch == epoch) live++;
        exp_rv    = !hold_s && !redir_s && (live + expq.size() < DEPTH) && (pend.size() < DEPTH);
        rsp_stale = rsp_v && (redir_s || r.epoch != epoch);
        byp       = TB_BYP && rsp_v && !rsp_stale && (expq.size() == 0);
        exp_iv    = !redir_s && (expq.size() > 0 || byp);

        chk("req_valid", req_valid_o, exp_rv);
        if (exp_rv) chk("req_addr", req_addr_o, exp_req_pc);
        chk("inst_valid", inst_valid_o, exp_iv);
        if (exp_iv) begin
            if (expq.size() > 0) e = expq[0];
            else begin e.pc = r.addr; e.data = rom(r.addr); end
            chk("inst_pc", inst_pc_o, e.pc);
            chk("inst_data", inst_data_o, e.data);
            if (irdy_s) $display("pop  pc=%08h data=%08h cycle=%0d", e.pc, e.data, cyc);
        end
        chk("fifo_count", fifo_count_o, expq.size());

        if (exp_iv && irdy_s && expq.size() > 0) void'(expq.pop_front());
        if (rsp_v) begin
            void'(pend.pop_front());
            if (!rsp_stale && !(byp && irdy_s)) begin
                e.pc = r.addr; e.data = rom(r.addr);
                expq.push_back(e);
            end
        end
        if (exp_rv && rdy_s) begin
            if (cyc + lat_s > last_due) last_due = cyc + lat_s;
            else last_due++;
            pend.push_back('{exp_req_pc, epoch, last_due});
            exp_req_pc += 32'd4;
        end
        if (redir_s) begin
            expq.delete();
            epoch++;
            exp_req_pc = redir_pc_s;
        end
    endtask

    initial begin
        rst = 1'b1;
        hold_s = 0; redir_s = 0; rdy_s = 1; irdy_s = 1; redir_pc_s = '0; lat_s = 1;
        do_reset(3);

        // streaming at full rate
        repeat (30) step();
        // decode stalls: queue fills, issue stops
        irdy_s = 0;
        repeat (12) step();
        // hold while the full queue drains
        hold_s = 1; irdy_s = 1;
        repeat (5) step();
        hold_s = 0;
        // longer ROM latency, redirect with requests in flight
        lat_s = 3;
        repeat (6) step();
        redir_s = 1; redir_pc_s = 32'h100;
        step();
        redir_s = 0;
        repeat (15) step();
        // redirect to 0x20 with an empty queue and decode ready
        lat_s = 2;
        redir_s = 1; redir_pc_s = 32'h20;
        step();
        redir_s = 0;
        repeat (10) step();

        // random traffic, including wrap-around targets
        for (int k = 0; k < 1500; k++) begin
            hold_s  = ($urandom_range(0, 9) == 0);
            redir_s = ($urandom_range(0, 19) == 0);
            redir_pc_s = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
            rdy_s   = ($urandom_range(0, 9) < 7);
            irdy_s  = ($urandom_range(0, 9) < 6);
            lat_s   = $urandom_range(1, 4);
            step();
        end

        // reset in the middle of traffic
        do_reset(2);
        for (int k = 0; k < 500; k++) begin
            hold_s  = ($urandom_range(0, 9) == 0);
            redir_s = ($urandom_range(0, 24) == 0);
            redir_pc_s = $urandom & 32'h0000_03FC;
            rdy_s   = ($urandom_range(0, 9) < 8);
            irdy_s  = ($urandom_range(0, 9) < 7);
            lat_s   = $urandom_range(1, 3);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
